// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle driven by vga_timing_generator toward the image/palette
// lookup stage.
interface vga_timing_generator_if;
  logic       screenEnd;
  logic       active;
  logic       hSync;
  logic       vSync;
  logic [9:0] x;
  logic [8:0] y;

  modport master (output screenEnd, active, hSync, vSync, x, y);
  modport slave  (input  screenEnd, active, hSync, vSync, x, y);
endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster timing (default 640x480@60 on a 25 MHz pixel clock).
// Define VGA_TIMING_PIPE_EN to delay active/hSync/vSync/screenEnd by PIPE_STAGES.
module vga_timing_generator #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                   clk25,
  input  logic                   reset,
  vga_timing_generator_if.master vga
);

  localparam int unsigned H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  // 11-bit compare constants so a 1024-entry total or sync end cannot wrap
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(WIDTH);
  localparam logic [10:0] V_VIS    = 11'(HEIGHT);
  localparam logic [10:0] HS_START = 11'(WIDTH + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(HEIGHT + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(HEIGHT + V_FRONT + V_SYNC);

  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_vis;
  logic        v_vis;
  logic        active_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        screen_end_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if ({1'b0, h_count} == H_LAST) begin
      h_count <= '0;
      if ({1'b0, v_count} == V_LAST) v_count <= '0;
      else                           v_count <= v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  always_comb begin
    h_ext        = {1'b0, h_count};
    v_ext        = {1'b0, v_count};
    h_vis        = h_ext < H_VIS;
    v_vis        = v_ext < V_VIS;
    active_d     = h_vis && v_vis;
    hsync_d      = !((h_ext >= HS_START) && (h_ext < HS_END));
    vsync_d      = !((v_ext >= VS_START) && (v_ext < VS_END));
    screen_end_d = (h_ext == H_LAST) && (v_ext == V_LAST);
    x_d          = h_vis ? h_count : '0;
    y_d          = v_vis ? v_count[8:0] : '0;
  end

  // x/y always bypass the delay chain: they address the RAM whose latency it matches
  assign vga.x = x_d;
  assign vga.y = y_d;

`ifdef VGA_TIMING_PIPE_EN
  logic [PIPE_STAGES-1:0] active_pipe;
  logic [PIPE_STAGES-1:0] hsync_pipe;
  logic [PIPE_STAGES-1:0] vsync_pipe;
  logic [PIPE_STAGES-1:0] screen_end_pipe;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      active_pipe     <= '0;
      hsync_pipe      <= '1;
      vsync_pipe      <= '1;
      screen_end_pipe <= '0;
    end else begin
      active_pipe[0]     <= active_d;
      hsync_pipe[0]      <= hsync_d;
      vsync_pipe[0]      <= vsync_d;
      screen_end_pipe[0] <= screen_end_d;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        active_pipe[i]     <= active_pipe[i-1];
        hsync_pipe[i]      <= hsync_pipe[i-1];
        vsync_pipe[i]      <= vsync_pipe[i-1];
        screen_end_pipe[i] <= screen_end_pipe[i-1];
      end
    end
  end

  assign vga.active    = active_pipe[PIPE_STAGES-1];
  assign vga.hSync     = hsync_pipe[PIPE_STAGES-1];
  assign vga.vSync     = vsync_pipe[PIPE_STAGES-1];
  assign vga.screenEnd = screen_end_pipe[PIPE_STAGES-1];
`else
  logic unused_pipe_cfg;
  assign unused_pipe_cfg = ^PIPE_STAGES;

  assign vga.active    = active_d;
  assign vga.hSync     = hsync_d;
  assign vga.vSync     = vsync_d;
  assign vga.screenEnd = screen_end_d;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
module tb_vga_timing_generator;

`ifdef VGA_TIMING_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk25 = 1'b0;
  logic rst_main;
  logic rst_small;

  always #5 clk25 = ~clk25;

  vga_timing_generator_if ifc_main ();
  vga_timing_generator_if ifc_small ();

  vga_timing_generator dut_main (
    .clk25 (clk25),
    .reset (rst_main),
    .vga   (ifc_main.master)
  );

  vga_timing_generator #(
    .WIDTH       (8),
    .HEIGHT      (6),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (2),
    .V_FRONT     (1),
    .V_SYNC      (2),
    .V_BACK      (1),
    .PIPE_STAGES (2)
  ) dut_small (
    .clk25 (clk25),
    .reset (rst_small),
    .vga   (ifc_small.master)
  );

  typedef struct {
    logic [8*12-1:0] name;
    bit              dut;
    bit              cxy;
    logic [9:0]      x;
    logic [8:0]      y;
    bit              csig;
    logic            a, h, v, s;
  } exp_t;

  typedef struct {
    int   e;
    exp_t ex;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  bit   cur_dut;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add_xy(input int e, input logic [8*12-1:0] nm,
                        input logic [9:0] x, input logic [8:0] y);
    vec_t t;
    t.e = e;
    t.ex = '{name: nm, dut: cur_dut, cxy: 1'b1, x: x, y: y, csig: 1'b0,
             a: 1'b0, h: 1'b0, v: 1'b0, s: 1'b0};
    tbl.push_back(t);
  endtask

  task automatic add_sig(input int e, input logic [8*12-1:0] nm,
                         input logic a, input logic h, input logic v, input logic s);
    vec_t t;
    t.e = e + L;
    t.ex = '{name: nm, dut: cur_dut, cxy: 1'b0, x: '0, y: '0, csig: 1'b1,
             a: a, h: h, v: v, s: s};
    tbl.push_back(t);
  endtask

  task automatic push_reset_exp(input logic [8*12-1:0] nm, input bit d);
    exp_t ex;
    ex = '{name: nm, dut: d, cxy: 1'b1, x: '0, y: '0, csig: 1'b1,
           a: (L == 0), h: 1'b1, v: 1'b1, s: 1'b0};
    sbq.push_back(ex);
  endtask

  task automatic check_reset_now(input string nm, input bit d);
    logic [9:0] gx;
    logic [8:0] gy;
    logic ga, gh, gv, gs;
    if (d) begin
      gx = ifc_small.x; gy = ifc_small.y; ga = ifc_small.active;
      gh = ifc_small.hSync; gv = ifc_small.vSync; gs = ifc_small.screenEnd;
    end else begin
      gx = ifc_main.x; gy = ifc_main.y; ga = ifc_main.active;
      gh = ifc_main.hSync; gv = ifc_main.vSync; gs = ifc_main.screenEnd;
    end
    n_checks++;
    if ((gx !== 10'd0) || (gy !== 9'd0) || (ga !== logic'(L == 0)) ||
        (gh !== 1'b1) || (gv !== 1'b1) || (gs !== 1'b0)) begin
      n_fail++;
      $display("FAIL %0s: immediate reset state x=%0d y=%0d act=%b hs=%b vs=%b se=%b",
               nm, gx, gy, ga, gh, gv, gs);
    end
  endtask

  task automatic run_table(input int max_e);
    for (int e = 0; e <= max_e; e++) begin
      foreach (tbl[i]) if (tbl[i].e == e) sbq.push_back(tbl[i].ex);
      if (e < max_e) begin
        @(posedge clk25);
        #1;
      end
    end
    tbl.delete();
  endtask

  always @(negedge clk25) begin
    while (sbq.size() > 0) begin
      exp_t ex;
      logic [9:0] gx;
      logic [8:0] gy;
      logic ga, gh, gv, gs;
      bit ok;
      ex = sbq.pop_front();
      if (ex.dut) begin
        gx = ifc_small.x; gy = ifc_small.y; ga = ifc_small.active;
        gh = ifc_small.hSync; gv = ifc_small.vSync; gs = ifc_small.screenEnd;
      end else begin
        gx = ifc_main.x; gy = ifc_main.y; ga = ifc_main.active;
        gh = ifc_main.hSync; gv = ifc_main.vSync; gs = ifc_main.screenEnd;
      end
      ok = 1'b1;
      if (ex.cxy && ((gx !== ex.x) || (gy !== ex.y))) ok = 1'b0;
      if (ex.csig && ((ga !== ex.a) || (gh !== ex.h) || (gv !== ex.v) || (gs !== ex.s)))
        ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %0s: got x=%0d y=%0d act=%b hs=%b vs=%b se=%b, want x=%0d y=%0d act=%b hs=%b vs=%b se=%b (xy=%0b sig=%0b)",
                 ex.name, gx, gy, ga, gh, gv, gs, ex.x, ex.y, ex.a, ex.h, ex.v, ex.s,
                 ex.cxy, ex.csig);
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL timeout: test did not finish within the wait limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_main  = 1'b0;
    rst_small = 1'b0;
    #1;
    check_reset_now("rst_main_now", 1'b0);
    check_reset_now("rst_small_now", 1'b1);
    repeat (3) @(posedge clk25);
    #1;
    push_reset_exp("rst_main", 1'b0);
    push_reset_exp("rst_small", 1'b1);
    repeat (2) @(posedge clk25);
    #1;
    rst_main = 1'b1;

    cur_dut = 1'b0;
    add_xy(0,    "rel_xy",   10'd0,   9'd0);
    add_xy(1,    "x_step1",  10'd1,   9'd0);
    add_xy(639,  "x_last",   10'd639, 9'd0);
    add_xy(640,  "x_blank",  10'd0,   9'd0);
    add_xy(799,  "x_hend",   10'd0,   9'd0);
    add_xy(800,  "y_wrap",   10'd0,   9'd1);
    add_xy(1605, "xy_5_2",   10'd5,   9'd2);
    add_sig(0,    "rel_sig",  1'b1, 1'b1, 1'b1, 1'b0);
    add_sig(639,  "act_639",  1'b1, 1'b1, 1'b1, 1'b0);
    add_sig(640,  "act_640",  1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(655,  "hs_655",   1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(656,  "hs_656",   1'b0, 1'b0, 1'b1, 1'b0);
    add_sig(751,  "hs_751",   1'b0, 1'b0, 1'b1, 1'b0);
    add_sig(752,  "hs_752",   1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(799,  "sig_799",  1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(800,  "sig_800",  1'b1, 1'b1, 1'b1, 1'b0);
    add_sig(1456, "hs_line1", 1'b0, 1'b0, 1'b1, 1'b0);
    run_table(1605);

    @(posedge clk25);
    #1;
    rst_small = 1'b1;
    cur_dut = 1'b1;
    add_xy(0,   "s_rel",    10'd0, 9'd0);
    add_xy(82,  "s_xy_7_5", 10'd7, 9'd5);
    add_xy(83,  "s_x_blnk", 10'd0, 9'd5);
    add_xy(149, "s_xy_end", 10'd0, 9'd0);
    add_xy(150, "s_xy_new", 10'd0, 9'd0);
    add_xy(151, "s_x1",     10'd1, 9'd0);
    add_xy(183, "s_xy_3_2", 10'd3, 9'd2);
    add_sig(12,  "s_hs_12",  1'b0, 1'b0, 1'b1, 1'b0);
    add_sig(13,  "s_hs_13",  1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(82,  "s_act",    1'b1, 1'b1, 1'b1, 1'b0);
    add_sig(83,  "s_act_off", 1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(100, "s_hs_vbl", 1'b0, 1'b0, 1'b1, 1'b0);
    add_sig(104, "s_vs_pre", 1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(105, "s_vs_fall", 1'b0, 1'b1, 1'b0, 1'b0);
    add_sig(134, "s_vs_low", 1'b0, 1'b1, 1'b0, 1'b0);
    add_sig(135, "s_vs_rise", 1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(148, "s_se_pre", 1'b0, 1'b1, 1'b1, 1'b0);
    add_sig(149, "s_se",     1'b0, 1'b1, 1'b1, 1'b1);
    add_sig(150, "s_se_post", 1'b1, 1'b1, 1'b1, 1'b0);
    run_table(183);

    @(posedge clk25);
    #1;
    rst_small = 1'b0;
    #1;
    check_reset_now("s_arst_now", 1'b1);
    push_reset_exp("s_arst", 1'b1);
    @(posedge clk25);
    #1;
    push_reset_exp("s_arst_hold", 1'b1);
    repeat (2) @(posedge clk25);
    #1;
    rst_small = 1'b1;

    add_xy(0,   "r_rel",    10'd0, 9'd0);
    add_xy(112, "r_xy_old", 10'd7, 9'd0);
    add_xy(149, "r_xy_end", 10'd0, 9'd0);
    add_xy(150, "r_xy_new", 10'd0, 9'd0);
    add_sig(0,   "r_rel_sig", 1'b1, 1'b1, 1'b1, 1'b0);
    add_sig(112, "r_no_se",  1'b0, 1'b1, 1'b0, 1'b0);
    add_sig(149, "r_se",     1'b0, 1'b1, 1'b1, 1'b1);
    add_sig(150, "r_se_post", 1'b1, 1'b1, 1'b1, 1'b0);
    run_table(152);

    @(negedge clk25);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
